mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the 5-stage RV32I pipeline: the upstream writer of the MEM/WB register. Takes the instruction held in EX/MEM, passes ALU results straight through, and runs a multi-cycle FSM for loads and stores over the byte-wide memory port. While an access is in flight it holds the pipeline via `stallreq`. On the final cycle it presents the write-back triple (`mem_wd`, `mem_wreg`, `mem_wdata`) for MEM/WB to latch.

## Interface
- No parameters; widths come from the shared defines (`RegBus` = 32, `RegAddrBus` = 5, `MemOpBus` = 4).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_wd`  in  5  destination register.
- `ex_wreg`  in  1  write-enable.
- `ex_wdata`  in  32  ALU result.
- `ex_memop`  in  4  one of NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
- `ex_maddr`  in  32  effective address.
- `ex_sdata`  in  32  store data.
- `mem_req`  out  1  byte access request.
- `mem_we`  out  1  1 = write.
- `mem_a`  out  32  byte address.
- `mem_dout`  out  8  write byte.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_din`  in  8  read byte, valid exactly one cycle after the granted read.
- `mem_wd`  out  5  to MEM/WB.
- `mem_wreg`  out  1  to MEM/WB.
- `mem_wdata`  out  32  to MEM/WB.
- `stallreq`  out  1  stall request to the stall controller; freezes stages 0–5.

## Operation
- FSM states: IDLE, BUSY, FIN. Registers: `state`, byte counter `cnt[1:0]`, byte count `nbytes` (1/2/4), data buffer `buf[31:0]`.
- IDLE, memop NONE:
  - Outputs combinationally equal `ex_wd`/`ex_wreg`/`ex_wdata`.
  - `stallreq` = 0; `mem_req` = 0.
- IDLE, load/store:
  - `stallreq` = 1; `mem_wreg` = 0.
  - Next state BUSY; `cnt` = 0; `nbytes` latched from memop.
- BUSY:
  - `mem_req` = 1, `mem_we` = store, `mem_a` = `ex_maddr + cnt` (32-bit wrap-around).
  - For stores, `mem_dout` = `ex_sdata[8*cnt+7 : 8*cnt]` (little-endian).
  - On `mem_gnt`, `cnt` increments. If `mem_gnt` = 0, address and data are held unchanged.
  - Each read byte arriving on `mem_din` is written into `buf` lane (index of the granted byte).
  - When the grant for byte `nbytes-1` occurs, next state is FIN.
  - `stallreq` = 1; `mem_wreg` = 0.
- FIN:
  - `stallreq` = 0; `mem_req` = 0.
  - Loads: last byte is taken combinationally from `mem_din`, merged with `buf`, then extended. `mem_wdata` = extended value; `mem_wd`/`mem_wreg` come from EX.
  - Extension rules: LB sign-extends bit 7, LH sign-extends bit 15, LBU/LHU zero-extend, LW takes all 32 bits.
  - Stores: `mem_wreg` = `ex_wreg` (0 from decode); `mem_wdata` = `ex_wdata`.
  - Next state IDLE.
- EX/MEM contents are stable while `stallreq` = 1, and advance on the FIN cycle. The next cycle therefore presents a new instruction.
- Misaligned addresses are legal; each access is byte-wise, with no trap.
- Reset (at any time, including mid-access) immediately forces:
  - `state` = IDLE, `cnt` = 0, `buf` = 0.
  - `mem_req` = 0, `mem_we` = 0, `mem_a` = 0, `mem_dout` = 0.
  - `stallreq` = 0, `mem_wd` = 0, `mem_wreg` = 0, `mem_wdata` = 0.
  - A partially completed store is not rolled back.

## Timing
- Non-memory op: 0 extra cycles; combinational pass-through.
- With `mem_gnt` tied high, an N-byte access takes N+2 cycles: IDLE(1) + BUSY(N) + FIN(1).
  - `stallreq` is high for N+1 cycles.
  - LB = 3 cycles, LH = 4, LW = 6.
- Each cycle of `mem_gnt` = 0 in BUSY adds exactly 1 cycle.
- Read data is never sampled except in the cycle after a grant.

## Structure
- Shared defines header holds:
  - memop encodings (`MemOpBus`, `MemNone`, `MemLB` … `MemSW`)
  - FSM state encodings
  - the existing `RegBus`, `RegAddrBus`, `ZeroWord`, `WriteDisable`, `RstEnable`.
- One natural combinational sub-module, `load_extend`: inputs are the merged 32-bit byte buffer and the memop; output is the extended 32-bit value.

## Test plan
- Pass-through: memop NONE, wd = 5, wreg = 1, wdata = 0x00001234 -> same-cycle outputs identical, `stallreq` = 0, `mem_req` never asserted.
- LW at 0x100, memory 78 56 34 12, gnt tied 1 -> reads 0x100..0x103 in cycles 1–4; `stallreq` high in cycles 0–4; cycle 5 `mem_wdata` = 0x12345678, `mem_wreg` = 1.
- Extension: byte 0x80 at 0x200 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at 0xFFFFFFFF with bytes FE, FF -> second address 0x00000000, result 0xFFFFFFFE.
- SH at 0x2FF, sdata 0xAABBCCDD -> writes DD@0x2FF, then CC@0x300, `mem_we` = 1; FIN shows `mem_wreg` = 0.
- SW with `mem_gnt` low for 2 cycles at byte 2 -> `mem_a`/`mem_dout` held; total latency 8 cycles.
- `rst` pulsed mid-LW after 2 grants -> `mem_req` and `stallreq` drop immediately; re-presented LW restarts at byte 0 and returns the correct word.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared widths, memory-op encodings, FSM states and small
//               decode helpers for the memory-access pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int MemOpBus   = 4;

   localparam logic [RegBus-1:0] ZeroWord     = '0;
   localparam logic              WriteDisable = 1'b0;
   localparam logic              RstEnable    = 1'b1;

   // Memory operation encodings carried in EX/MEM
   localparam logic [MemOpBus-1:0] MemNone = 4'd0;
   localparam logic [MemOpBus-1:0] MemLB   = 4'd1;
   localparam logic [MemOpBus-1:0] MemLH   = 4'd2;
   localparam logic [MemOpBus-1:0] MemLW   = 4'd3;
   localparam logic [MemOpBus-1:0] MemLBU  = 4'd4;
   localparam logic [MemOpBus-1:0] MemLHU  = 4'd5;
   localparam logic [MemOpBus-1:0] MemSB   = 4'd6;
   localparam logic [MemOpBus-1:0] MemSH   = 4'd7;
   localparam logic [MemOpBus-1:0] MemSW   = 4'd8;

   // Access sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   function automatic logic is_load(input logic [MemOpBus-1:0] op);
      return (op == MemLB) || (op == MemLH) || (op == MemLW) ||
             (op == MemLBU) || (op == MemLHU);
   endfunction

   function automatic logic is_store(input logic [MemOpBus-1:0] op);
      return (op == MemSB) || (op == MemSH) || (op == MemSW);
   endfunction

   // Number of bytes moved by an access (1, 2 or 4); 0 for non-memory ops
   function automatic logic [2:0] memop_nbytes(input logic [MemOpBus-1:0] op);
      logic [2:0] n;
      n = 3'd0;
      if ((op == MemLB) || (op == MemLBU) || (op == MemSB)) n = 3'd1;
      if ((op == MemLH) || (op == MemLHU) || (op == MemSH)) n = 3'd2;
      if ((op == MemLW) || (op == MemSW))                   n = 3'd4;
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_if
// Description : Byte-wide memory port between the memory-access stage
//               (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if;
   import mem_access_pkg::*;

   logic              mem_req;
   logic              mem_we;
   logic [RegBus-1:0] mem_a;
   logic [7:0]        mem_dout;
   logic              mem_gnt;
   logic [7:0]        mem_din;

   modport master (
      output mem_req, mem_we, mem_a, mem_dout,
      input  mem_gnt, mem_din
   );

   modport slave (
      input  mem_req, mem_we, mem_a, mem_dout,
      output mem_gnt, mem_din
   );

endinterface
`default_nettype wire

// File: rtl/mem_access_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Sign/zero extension of the assembled load data according to
//               the load flavour. Non-load ops pass the word unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
   import mem_access_pkg::*;
(
   input  wire logic [RegBus-1:0]   i_data,
   input  wire logic [MemOpBus-1:0] i_memop,
   output logic      [RegBus-1:0]   o_data
);

   // Select the extension rule from the memop
   always_comb begin
      o_data = i_data;
      case (i_memop)
         MemLB:   o_data = {{24{i_data[7]}},  i_data[7:0]};
         MemLBU:  o_data = {24'd0,            i_data[7:0]};
         MemLH:   o_data = {{16{i_data[15]}}, i_data[15:0]};
         MemLHU:  o_data = {16'd0,            i_data[15:0]};
         default: o_data = i_data;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory-access stage of the RV32I pipeline. ALU results pass
//               straight through; loads and stores are sequenced byte by byte
//               over the memory port while the pipeline is stalled, and the
//               write-back triple is presented on the final cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
   import mem_access_pkg::*;
(
   input  wire logic                  clk,
   input  wire logic                  rst,

   input  wire logic [RegAddrBus-1:0] ex_wd,
   input  wire logic                  ex_wreg,
   input  wire logic [RegBus-1:0]     ex_wdata,
   input  wire logic [MemOpBus-1:0]   ex_memop,
   input  wire logic [RegBus-1:0]     ex_maddr,
   input  wire logic [RegBus-1:0]     ex_sdata,

   mem_access_if.master               mif,

   output logic      [RegAddrBus-1:0] mem_wd,
   output logic                       mem_wreg,
   output logic      [RegBus-1:0]     mem_wdata,
   output logic                       stallreq
);

   state_t            r_state;
   logic [1:0]        r_cnt;
   logic [2:0]        r_nbytes;
   logic [RegBus-1:0] r_buf;
   // A read byte is due on mem_din this cycle, destined for lane r_lane
   logic              r_pend;
   logic [1:0]        r_lane;

   logic              w_is_load;
   logic              w_is_store;
   logic              w_last_byte;
   logic [RegBus-1:0] w_sdata_sh;
   logic [RegBus-1:0] w_merged;
   logic [RegBus-1:0] w_ext;

   assign w_is_load   = is_load(ex_memop);
   assign w_is_store  = is_store(ex_memop);
   assign w_last_byte = ({1'b0, r_cnt} == (r_nbytes - 3'd1));
   assign w_sdata_sh  = ex_sdata >> {r_cnt, 3'b000};

   // Current buffer with the byte arriving this cycle folded in
   always_comb begin
      w_merged = r_buf;
      if (r_pend) begin
         w_merged[{r_lane, 3'b000} +: 8] = mif.mem_din;
      end
   end

   load_extend u_load_extend (
      .i_data  (w_merged),
      .i_memop (ex_memop),
      .o_data  (w_ext)
   );

   // Access sequencer: state, byte counter, read-data capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 2'd0;
         r_nbytes <= 3'd0;
         r_buf    <= ZeroWord;
         r_pend   <= 1'b0;
         r_lane   <= 2'd0;
      end else begin
         r_pend <= 1'b0;
         if (r_pend) begin
            r_buf[{r_lane, 3'b000} +: 8] <= mif.mem_din;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_is_load || w_is_store) begin
                  r_state  <= ST_BUSY;
                  r_cnt    <= 2'd0;
                  r_nbytes <= memop_nbytes(ex_memop);
                  r_buf    <= ZeroWord;
               end
            end
            ST_BUSY: begin
               if (mif.mem_gnt) begin
                  r_cnt <= r_cnt + 2'd1;
                  if (w_is_load) begin
                     r_pend <= 1'b1;
                     r_lane <= r_cnt;
                  end
                  if (w_last_byte) begin
                     r_state <= ST_FIN;
                  end
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
               r_cnt   <= 2'd0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 2'd0;
            end
         endcase
      end
   end

   // Output decode; reset forces every output low without waiting for a clock
   always_comb begin
      mif.mem_req  = 1'b0;
      mif.mem_we   = 1'b0;
      mif.mem_a    = ZeroWord;
      mif.mem_dout = 8'd0;
      stallreq     = 1'b0;
      mem_wd       = '0;
      mem_wreg     = WriteDisable;
      mem_wdata    = ZeroWord;
      if (rst != RstEnable) begin
         case (r_state)
            ST_IDLE: begin
               mem_wd    = ex_wd;
               mem_wdata = ex_wdata;
               if (w_is_load || w_is_store) begin
                  stallreq = 1'b1;
               end else begin
                  mem_wreg = ex_wreg;
               end
            end
            ST_BUSY: begin
               mif.mem_req = 1'b1;
               mif.mem_we  = w_is_store;
               mif.mem_a   = ex_maddr + {30'd0, r_cnt};
               if (w_is_store) begin
                  mif.mem_dout = w_sdata_sh[7:0];
               end
               stallreq  = 1'b1;
               mem_wd    = ex_wd;
               mem_wdata = ex_wdata;
            end
            ST_FIN: begin
               mem_wd    = ex_wd;
               mem_wreg  = ex_wreg;
               mem_wdata = w_is_load ? w_ext : ex_wdata;
            end
            default: begin
               mem_wd = ex_wd;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for the memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk;
   logic        rst;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_memop;
   logic [31:0] ex_maddr;
   logic [31:0] ex_sdata;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stallreq;

   logic        gnt_r;
   logic [7:0]  din_r;
   logic [7:0]  mem [0:4095];

   int n_checks;
   int n_fail;

   // Results captured by run_access
   logic [31:0] res_data;
   logic        res_wreg;
   logic [4:0]  res_wd;
   int          res_cycles;
   int          res_nstall;
   int          stall_byte;
   int          stall_left;
   logic [31:0] q_a[$];
   logic [7:0]  q_d[$];
   logic        q_we[$];

   mem_access_if mif ();

   assign mif.mem_gnt = gnt_r;
   assign mif.mem_din = din_r;

   mem_access dut (
      .clk       (clk),
      .rst       (rst),
      .ex_wd     (ex_wd),
      .ex_wreg   (ex_wreg),
      .ex_wdata  (ex_wdata),
      .ex_memop  (ex_memop),
      .ex_maddr  (ex_maddr),
      .ex_sdata  (ex_sdata),
      .mif       (mif),
      .mem_wd    (mem_wd),
      .mem_wreg  (mem_wreg),
      .mem_wdata (mem_wdata),
      .stallreq  (stallreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-only byte memory; returns data one cycle after a granted read,
   // and junk at all other times
   always @(posedge clk) begin
      if (mif.mem_req && mif.mem_gnt && !mif.mem_we)
         din_r <= mem[mif.mem_a[11:0]];
      else
         din_r <= 8'hA5;
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] wd,
                        input logic wreg, input logic [31:0] wdata);
      ex_memop = op;
      ex_maddr = addr;
      ex_sdata = sdata;
      ex_wd    = wd;
      ex_wreg  = wreg;
      ex_wdata = wdata;
   endtask

   // Runs one presented access to its FIN cycle, logging requests
   task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [4:0] wd,
                             input logic wreg, input logic [31:0] wdata);
      int  g;
      bit  done;
      g = 0;
      done = 0;
      res_cycles = -1;
      res_nstall = 0;
      q_a.delete();
      q_d.delete();
      q_we.delete();
      drive(op, addr, sdata, wd, wreg, wdata);
      for (int c = 0; c < 40; c++) begin
         gnt_r = !((g == stall_byte) && (stall_left > 0));
         @(negedge clk);
         if (stallreq) res_nstall++;
         if (mif.mem_req) begin
            q_a.push_back(mif.mem_a);
            q_d.push_back(mif.mem_dout);
            q_we.push_back(mif.mem_we);
            if (gnt_r) g++;
            else stall_left--;
         end
         if ((c > 0) && !stallreq) begin
            res_data   = mem_wdata;
            res_wreg   = mem_wreg;
            res_wd     = mem_wd;
            res_cycles = c + 1;
            done       = 1;
         end
         @(posedge clk);
         #1;
         if (done) break;
      end
      gnt_r      = 1'b1;
      stall_byte = -1;
      stall_left = 0;
      drive(MemNone, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(MemLW, 32'h100, 32'hDEADBEEF, 5'd5, 1'b1, 32'h1234);
      @(negedge clk);
      n_checks++;
      if ({mif.mem_req, mif.mem_we, stallreq, mem_wreg} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: req/we/stall/wreg=%b expected 0000",
                  {mif.mem_req, mif.mem_we, stallreq, mem_wreg});
      end
      n_checks++;
      if ({mif.mem_a, mif.mem_dout, mem_wd, mem_wdata} !== 77'd0) begin
         n_fail++;
         $display("FAIL reset_data: a=%h dout=%h wd=%0d wdata=%h expected all zero",
                  mif.mem_a, mif.mem_dout, mem_wd, mem_wdata);
      end
      @(posedge clk);
      #1;
      drive(MemNone, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      drive(MemNone, 32'h300, 32'h0, 5'd5, 1'b1, 32'h00001234);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({mem_wd, mem_wreg, mem_wdata, stallreq, mif.mem_req} !==
             {5'd5, 1'b1, 32'h00001234, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL passthrough[%0d]: wd=%0d wreg=%b wdata=%h stall=%b req=%b expected 5 1 00001234 0 0",
                     i, mem_wd, mem_wreg, mem_wdata, stallreq, mif.mem_req);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_lw();
      run_access(MemLW, 32'h100, 32'h0, 5'd7, 1'b1, 32'hCAFE0000);
      n_checks++;
      if ({res_data, res_wreg, res_wd} !== {32'h12345678, 1'b1, 5'd7}) begin
         n_fail++;
         $display("FAIL lw_result: data=%h wreg=%b wd=%0d expected 12345678 1 7",
                  res_data, res_wreg, res_wd);
      end
      n_checks++;
      if (res_cycles != 6 || res_nstall != 5) begin
         n_fail++;
         $display("FAIL lw_timing: cycles=%0d stall=%0d expected 6 5", res_cycles, res_nstall);
      end
      n_checks++;
      if (q_a.size() != 4 || q_a[0] !== 32'h100 || q_a[1] !== 32'h101 ||
          q_a[2] !== 32'h102 || q_a[3] !== 32'h103 || q_we[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL lw_addr: n=%0d first=%h last=%h we=%b expected 4 100 103 0",
                  q_a.size(), q_a[0], q_a[q_a.size()-1], q_we[0]);
      end
   endtask

   task automatic test_extend();
      run_access(MemLB, 32'h200, 32'h0, 5'd1, 1'b1, 32'h0);
      n_checks++;
      if (res_data !== 32'hFFFFFF80 || res_cycles != 3) begin
         n_fail++;
         $display("FAIL lb_ext: data=%h cycles=%0d expected FFFFFF80 3", res_data, res_cycles);
      end
      run_access(MemLBU, 32'h200, 32'h0, 5'd1, 1'b1, 32'h0);
      n_checks++;
      if (res_data !== 32'h00000080) begin
         n_fail++;
         $display("FAIL lbu_ext: data=%h expected 00000080", res_data);
      end
      run_access(MemLH, 32'hFFFFFFFF, 32'h0, 5'd2, 1'b1, 32'h0);
      n_checks++;
      if (res_data !== 32'hFFFFFFFE || res_cycles != 4) begin
         n_fail++;
         $display("FAIL lh_wrap: data=%h cycles=%0d expected FFFFFFFE 4", res_data, res_cycles);
      end
      n_checks++;
      if (q_a.size() != 2 || q_a[1] !== 32'h00000000) begin
         n_fail++;
         $display("FAIL lh_wrap_addr: n=%0d second=%h expected 2 00000000", q_a.size(), q_a[1]);
      end
      run_access(MemLHU, 32'hFFFFFFFF, 32'h0, 5'd2, 1'b1, 32'h0);
      n_checks++;
      if (res_data !== 32'h0000FFFE) begin
         n_fail++;
         $display("FAIL lhu_ext: data=%h expected 0000FFFE", res_data);
      end
   endtask

   task automatic test_store_sh();
      run_access(MemSH, 32'h2FF, 32'hAABBCCDD, 5'd0, 1'b0, 32'h00000055);
      n_checks++;
      if (q_a.size() != 2 || q_a[0] !== 32'h2FF || q_d[0] !== 8'hDD ||
          q_a[1] !== 32'h300 || q_d[1] !== 8'hCC || q_we[0] !== 1'b1 || q_we[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL sh_bytes: n=%0d a0=%h d0=%h a1=%h d1=%h we=%b%b expected 2 2FF DD 300 CC 11",
                  q_a.size(), q_a[0], q_d[0], q_a[1], q_d[1], q_we[0], q_we[1]);
      end
      n_checks++;
      if (res_wreg !== 1'b0 || res_data !== 32'h00000055 || res_cycles != 4) begin
         n_fail++;
         $display("FAIL sh_fin: wreg=%b data=%h cycles=%0d expected 0 00000055 4",
                  res_wreg, res_data, res_cycles);
      end
   endtask

   task automatic test_store_stall();
      logic [31:0] exp_a [6];
      logic [7:0]  exp_d [6];
      exp_a = '{32'h400, 32'h401, 32'h402, 32'h402, 32'h402, 32'h403};
      exp_d = '{8'h44, 8'h33, 8'h22, 8'h22, 8'h22, 8'h11};
      stall_byte = 2;
      stall_left = 2;
      run_access(MemSW, 32'h400, 32'h11223344, 5'd0, 1'b0, 32'h0);
      n_checks++;
      if (res_cycles != 8 || res_nstall != 7) begin
         n_fail++;
         $display("FAIL sw_stall_timing: cycles=%0d stall=%0d expected 8 7", res_cycles, res_nstall);
      end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (q_a.size() != 6 || q_a[i] !== exp_a[i] || q_d[i] !== exp_d[i]) begin
            n_fail++;
            $display("FAIL sw_stall_req[%0d]: n=%0d a=%h d=%h expected 6 %h %h",
                     i, q_a.size(), q_a[i], q_d[i], exp_a[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_reset_mid_access();
      gnt_r = 1'b1;
      drive(MemLW, 32'h100, 32'h0, 5'd9, 1'b1, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (mif.mem_req !== 1'b1 || stallreq !== 1'b1 || mif.mem_a !== 32'h102) begin
         n_fail++;
         $display("FAIL mid_before_rst: req=%b stall=%b a=%h expected 1 1 102",
                  mif.mem_req, stallreq, mif.mem_a);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (mif.mem_req !== 1'b0 || stallreq !== 1'b0 || mif.mem_a !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_rst_drop: req=%b stall=%b a=%h expected 0 0 0",
                  mif.mem_req, stallreq, mif.mem_a);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_access(MemLW, 32'h100, 32'h0, 5'd9, 1'b1, 32'h0);
      n_checks++;
      if (res_data !== 32'h12345678 || res_cycles != 6 || q_a.size() != 4 || q_a[0] !== 32'h100) begin
         n_fail++;
         $display("FAIL mid_rst_replay: data=%h cycles=%0d n=%0d a0=%h expected 12345678 6 4 100",
                  res_data, res_cycles, q_a.size(), q_a[0]);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      gnt_r      = 1'b1;
      stall_byte = -1;
      stall_left = 0;
      rst        = 1'b1;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'h100] = 8'h78;
      mem[12'h101] = 8'h56;
      mem[12'h102] = 8'h34;
      mem[12'h103] = 8'h12;
      mem[12'h200] = 8'h80;
      mem[12'hFFF] = 8'hFE;
      mem[12'h000] = 8'hFF;
      drive(MemNone, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);

      test_reset();
      test_passthrough();
      test_lw();
      test_extend();
      test_store_sh();
      test_store_stall();
      test_reset_mid_access();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
